// File: rtl/dcache_responder_if.sv
// Memory-stage data port plus backing-memory req/ack channel of the data cache.
interface dcache_responder_if #(
    parameter int unsigned ADDR_W = 32
);
    // Pipeline side
    logic              iReqValid;
    logic              iWriteEn;
    logic [ADDR_W-1:0] iAddress;
    logic [31:0]       iWriteData;
    logic [3:0]        iByteEn;
    logic              iInvalidate;
    logic [31:0]       oReadData;
    logic              oStall;
    logic [31:0]       oHitCount;
    logic [31:0]       oMissCount;

    // Backing-memory side
    logic              oMemReq;
    logic              oMemWe;
    logic [ADDR_W-1:0] oMemAddr;
    logic [31:0]       oMemWData;
    logic [3:0]        oMemBe;
    logic              iMemAck;
    logic [31:0]       iMemRData;

    // Cache responder view
    modport slave (
        input  iReqValid, iWriteEn, iAddress, iWriteData, iByteEn, iInvalidate,
        input  iMemAck, iMemRData,
        output oReadData, oStall, oHitCount, oMissCount,
        output oMemReq, oMemWe, oMemAddr, oMemWData, oMemBe
    );

    // Pipeline/memory environment view
    modport master (
        output iReqValid, iWriteEn, iAddress, iWriteData, iByteEn, iInvalidate,
        output iMemAck, iMemRData,
        input  oReadData, oStall, oHitCount, oMissCount,
        input  oMemReq, oMemWe, oMemAddr, oMemWData, oMemBe
    );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache for the M stage.
// Load hits return data in the same cycle; misses and stores stall the
// pipeline until the backing memory acknowledges.
module dcache_responder #(
    parameter int unsigned LINES  = 16,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              iClk,
    input  logic              iRstN,
    dcache_responder_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = ADDR_W - 2 - IDX_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WTHRU  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_q;
    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [31:0]       data_q [LINES];

    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [3:0]        mem_be_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [31:0]       resp_q;
    logic [31:0]       hit_q;
    logic [31:0]       miss_q;

    logic [IDX_W-1:0]  req_idx_c;
    logic [TAG_W-1:0]  req_tag_c;
    logic              hit_c;
    logic              load_hit_c;
    logic [IDX_W-1:0]  lat_idx_c;
    logic [TAG_W-1:0]  lat_tag_c;
    logic              lat_hit_c;
    logic              stall_c;
    logic [31:0]       read_data_c;
    logic              unused_c;

    // Byte-lane merge of store data into an existing line
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_d,
                                                input logic [31:0] new_d,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? new_d[8*b +: 8] : old_d[8*b +: 8];
        end
        return res;
    endfunction

    // Lookup of the incoming request and of the latched request
    assign req_idx_c  = bus.iAddress[2 +: IDX_W];
    assign req_tag_c  = bus.iAddress[ADDR_W-1 -: TAG_W];
    assign hit_c      = valid_q[req_idx_c] && (tag_q[req_idx_c] == req_tag_c);
    assign load_hit_c = bus.iReqValid && !bus.iWriteEn && hit_c;
    assign lat_idx_c  = mem_addr_q[2 +: IDX_W];
    assign lat_tag_c  = mem_addr_q[ADDR_W-1 -: TAG_W];
    assign lat_hit_c  = valid_q[lat_idx_c] && (tag_q[lat_idx_c] == lat_tag_c);
    assign unused_c   = ^bus.iAddress[1:0];

    // Controller: state, memory channel, response register, valid bits, counters
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            resp_q      <= 32'h0;
            hit_q       <= 32'h0;
            miss_q      <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.iReqValid) begin
                        if (bus.iWriteEn) begin
                            state_q     <= WTHRU;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {bus.iAddress[ADDR_W-1:2], 2'b00};
                            mem_wdata_q <= bus.iWriteData;
                            mem_be_q    <= bus.iByteEn;
                        end else if (hit_c) begin
                            hit_q <= hit_q + 32'd1;
                        end else begin
                            state_q    <= REFILL;
                            miss_q     <= miss_q + 32'd1;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_be_q   <= 4'b0;
                            mem_addr_q <= {bus.iAddress[ADDR_W-1:2], 2'b00};
                        end
                    end
                end
                REFILL: begin
                    if (bus.iMemAck) begin
                        valid_q[lat_idx_c] <= 1'b1;
                        resp_q             <= bus.iMemRData;
                        mem_req_q          <= 1'b0;
                        state_q            <= DONE;
                    end
                end
                WTHRU: begin
                    if (bus.iMemAck) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        mem_be_q  <= 4'b0;
                        state_q   <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            // Invalidate overrides any valid bit set by a coincident refill
            if (bus.iInvalidate) begin
                valid_q <= '0;
            end
        end
    end

    // Line storage: refill on read ack, byte merge on write-through ack of a hit
    always_ff @(posedge iClk) begin
        if ((state_q == REFILL) && bus.iMemAck) begin
            data_q[lat_idx_c] <= bus.iMemRData;
            tag_q[lat_idx_c]  <= lat_tag_c;
        end else if ((state_q == WTHRU) && bus.iMemAck && lat_hit_c) begin
            data_q[lat_idx_c] <= merge_bytes(data_q[lat_idx_c], mem_wdata_q, mem_be_q);
        end
    end

    // Same-cycle stall and load-data path
    always_comb begin
        stall_c     = 1'b0;
        read_data_c = resp_q;
        case (state_q)
            IDLE: begin
                stall_c = bus.iReqValid && (bus.iWriteEn || !hit_c);
                if (load_hit_c) begin
                    read_data_c = data_q[req_idx_c];
                end
            end
            REFILL, WTHRU: stall_c = 1'b1;
            default: stall_c = 1'b0;
        endcase
        if (!iRstN) begin
            stall_c = 1'b0;
        end
    end

    assign bus.oStall     = stall_c;
    assign bus.oReadData  = read_data_c;
    assign bus.oMemReq    = mem_req_q;
    assign bus.oMemWe     = mem_we_q;
    assign bus.oMemAddr   = mem_addr_q;
    assign bus.oMemWData  = mem_wdata_q;
    assign bus.oMemBe     = mem_be_q;
    assign bus.oHitCount  = hit_q;
    assign bus.oMissCount = miss_q;

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: reset, miss/hit, write-through,
// aliasing, invalidate interactions and hit-counter wrap.
module tb_dcache_responder;
    logic clk = 1'b0;
    logic rst_n;
    int   vecs = 0;
    int   errs = 0;

    // Backing-memory model controls
    int          mem_lat = 1;
    logic [31:0] mem_rdata = 32'h0;
    logic        inval_on_ack = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] seen_addr;
    logic        seen_we;
    logic [3:0]  seen_be;
    logic [31:0] seen_wdata;
    logic        mem_unstable = 1'b0;
    logic        inval_mem = 1'b0;
    logic        inval_tb = 1'b0;

    dcache_responder_if #(.ADDR_W(32)) bus ();

    dcache_responder #(.LINES(16), .ADDR_W(32)) dut (
        .iClk  (clk),
        .iRstN (rst_n),
        .bus   (bus)
    );

    assign bus.iInvalidate = inval_tb | inval_mem;

    always #5 clk = ~clk;

    // Backing memory: acks on the mem_lat-th cycle of a request, tracks stability
    always @(negedge clk) begin
        if (bus.oMemReq) begin
            mem_cnt = mem_cnt + 1;
            if (mem_cnt == 1) begin
                seen_addr    = bus.oMemAddr;
                seen_we      = bus.oMemWe;
                seen_be      = bus.oMemBe;
                seen_wdata   = bus.oMemWData;
                mem_unstable = 1'b0;
            end else if (bus.oMemAddr !== seen_addr || bus.oMemWe !== seen_we ||
                         bus.oMemBe !== seen_be || bus.oMemWData !== seen_wdata) begin
                mem_unstable = 1'b1;
            end
            bus.iMemAck   = (mem_cnt == mem_lat);
            bus.iMemRData = (mem_cnt == mem_lat) ? mem_rdata : 32'h0;
            inval_mem     = (mem_cnt == mem_lat) && inval_on_ack;
        end else begin
            mem_cnt       = 0;
            bus.iMemAck   = 1'b0;
            bus.iMemRData = 32'h0;
            inval_mem     = 1'b0;
        end
    end

    // One pipeline access; returns stall cycles and the data seen when the stall clears
    task automatic do_access(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be,
                             input int lat, input logic [31:0] mdata,
                             input logic inval_now,
                             output int stalls, output logic [31:0] rdata);
        mem_lat   = lat;
        mem_rdata = mdata;
        @(negedge clk);
        bus.iReqValid  = 1'b1;
        bus.iWriteEn   = we;
        bus.iAddress   = addr;
        bus.iWriteData = wdata;
        bus.iByteEn    = be;
        inval_tb       = inval_now;
        stalls = 0;
        #1;
        while (bus.oStall && stalls < 50) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (bus.oStall) begin
            vecs++;
            errs++;
            $display("FAIL access_timeout addr=%h stall still high after %0d cycles", addr, stalls);
        end
        rdata = bus.oReadData;
        @(negedge clk);
        bus.iReqValid = 1'b0;
        bus.iWriteEn  = 1'b0;
        inval_tb      = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        vecs++; if (bus.oStall !== 1'b0) begin errs++; $display("FAIL reset_stall got=%b exp=0", bus.oStall); end
        vecs++; if (bus.oMemReq !== 1'b0) begin errs++; $display("FAIL reset_memreq got=%b exp=0", bus.oMemReq); end
        vecs++; if (bus.oMemWe !== 1'b0 || bus.oMemBe !== 4'b0) begin errs++; $display("FAIL reset_we_be got=%b/%b exp=0/0000", bus.oMemWe, bus.oMemBe); end
        vecs++; if (bus.oReadData !== 32'h0 || bus.oMemAddr !== 32'h0 || bus.oMemWData !== 32'h0) begin errs++; $display("FAIL reset_data got=%h/%h/%h exp=0", bus.oReadData, bus.oMemAddr, bus.oMemWData); end
        vecs++; if (bus.oHitCount !== 32'h0 || bus.oMissCount !== 32'h0) begin errs++; $display("FAIL reset_counts got=%h/%h exp=0/0", bus.oHitCount, bus.oMissCount); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_refill;
        mem_lat   = 20;
        mem_rdata = 32'h55555555;
        @(negedge clk);
        bus.iReqValid = 1'b1;
        bus.iWriteEn  = 1'b0;
        bus.iAddress  = 32'h100;
        @(negedge clk);
        @(negedge clk);
        #1;
        vecs++; if (bus.oMemReq !== 1'b1) begin errs++; $display("FAIL midrefill_req got=%b exp=1", bus.oMemReq); end
        #1;
        rst_n = 1'b0;
        bus.iReqValid = 1'b0;
        #1;
        vecs++; if (bus.oMemReq !== 1'b0) begin errs++; $display("FAIL async_reset_req got=%b exp=0", bus.oMemReq); end
        vecs++; if (bus.oStall !== 1'b0 || bus.oMissCount !== 32'h0) begin errs++; $display("FAIL async_reset_state stall=%b miss=%h exp=0/0", bus.oStall, bus.oMissCount); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_miss_hit;
        int s; logic [31:0] d;
        do_access(1'b0, 32'h100, 32'h0, 4'h0, 3, 32'hDEADBEEF, 1'b0, s, d);
        vecs++; if (s !== 4) begin errs++; $display("FAIL miss_stall got=%0d exp=4", s); end
        vecs++; if (d !== 32'hDEADBEEF) begin errs++; $display("FAIL miss_data got=%h exp=deadbeef", d); end
        vecs++; if (seen_addr !== 32'h100 || seen_we !== 1'b0) begin errs++; $display("FAIL refill_req addr=%h we=%b exp=100/0", seen_addr, seen_we); end
        vecs++; if (bus.oMissCount !== 32'd1) begin errs++; $display("FAIL miss_count got=%0d exp=1", bus.oMissCount); end
        do_access(1'b0, 32'h100, 32'h0, 4'h0, 1, 32'h0, 1'b0, s, d);
        vecs++; if (s !== 0 || d !== 32'hDEADBEEF) begin errs++; $display("FAIL hit got stall=%0d data=%h exp=0/deadbeef", s, d); end
        vecs++; if (bus.oHitCount !== 32'd1) begin errs++; $display("FAIL hit_count got=%0d exp=1", bus.oHitCount); end
    endtask

    task automatic test_store_hit;
        int s; logic [31:0] d;
        do_access(1'b1, 32'h100, 32'h000000AA, 4'b0001, 2, 32'h0, 1'b0, s, d);
        vecs++; if (s !== 3) begin errs++; $display("FAIL store_stall got=%0d exp=3", s); end
        vecs++; if (seen_we !== 1'b1 || seen_be !== 4'b0001 || seen_addr !== 32'h100 || seen_wdata !== 32'hAA) begin errs++; $display("FAIL wthru_req we=%b be=%b addr=%h wd=%h exp=1/0001/100/aa", seen_we, seen_be, seen_addr, seen_wdata); end
        vecs++; if (mem_unstable !== 1'b0) begin errs++; $display("FAIL wthru_stable got=%b exp=0", mem_unstable); end
        do_access(1'b0, 32'h100, 32'h0, 4'h0, 1, 32'h0, 1'b0, s, d);
        vecs++; if (s !== 0 || d !== 32'hDEADBEAA) begin errs++; $display("FAIL merged_hit stall=%0d data=%h exp=0/deadbeaa", s, d); end
        vecs++; if (bus.oHitCount !== 32'd2 || bus.oMissCount !== 32'd1) begin errs++; $display("FAIL counts_after_store hit=%0d miss=%0d exp=2/1", bus.oHitCount, bus.oMissCount); end
    endtask

    task automatic test_store_miss;
        int s; logic [31:0] d;
        do_access(1'b1, 32'h202, 32'h12345678, 4'b1111, 1, 32'h0, 1'b0, s, d);
        vecs++; if (s !== 2) begin errs++; $display("FAIL store_miss_stall got=%0d exp=2", s); end
        vecs++; if (seen_we !== 1'b1 || seen_addr !== 32'h200) begin errs++; $display("FAIL store_miss_req we=%b addr=%h exp=1/200", seen_we, seen_addr); end
        do_access(1'b0, 32'h200, 32'h0, 4'h0, 1, 32'h12345678, 1'b0, s, d);
        vecs++; if (s !== 2 || d !== 32'h12345678) begin errs++; $display("FAIL no_allocate stall=%0d data=%h exp=2/12345678", s, d); end
        vecs++; if (bus.oMissCount !== 32'd2) begin errs++; $display("FAIL miss_count2 got=%0d exp=2", bus.oMissCount); end
    endtask

    task automatic test_alias;
        int s; logic [31:0] d;
        @(negedge clk); inval_tb = 1'b1;
        @(negedge clk); inval_tb = 1'b0;
        do_access(1'b0, 32'h100, 32'h0, 4'h0, 1, 32'h11110000, 1'b0, s, d);
        vecs++; if (s !== 2 || d !== 32'h11110000) begin errs++; $display("FAIL alias1 stall=%0d data=%h exp=2/11110000", s, d); end
        do_access(1'b0, 32'h140, 32'h0, 4'h0, 1, 32'h22220000, 1'b0, s, d);
        vecs++; if (s !== 2 || d !== 32'h22220000) begin errs++; $display("FAIL alias2 stall=%0d data=%h exp=2/22220000", s, d); end
        do_access(1'b0, 32'h100, 32'h0, 4'h0, 1, 32'h33330000, 1'b0, s, d);
        vecs++; if (s !== 2 || d !== 32'h33330000) begin errs++; $display("FAIL alias3 stall=%0d data=%h exp=2/33330000", s, d); end
        vecs++; if (bus.oMissCount !== 32'd5) begin errs++; $display("FAIL alias_misses got=%0d exp=5", bus.oMissCount); end
        do_access(1'b0, 32'h100, 32'h0, 4'h0, 1, 32'h0, 1'b0, s, d);
        vecs++; if (s !== 0 || d !== 32'h33330000) begin errs++; $display("FAIL alias_hit stall=%0d data=%h exp=0/33330000", s, d); end
    endtask

    task automatic test_invalidate;
        int s; logic [31:0] d;
        inval_on_ack = 1'b1;
        do_access(1'b0, 32'h300, 32'h0, 4'h0, 2, 32'hCAFEF00D, 1'b0, s, d);
        inval_on_ack = 1'b0;
        vecs++; if (s !== 3 || d !== 32'hCAFEF00D) begin errs++; $display("FAIL inval_refill stall=%0d data=%h exp=3/cafef00d", s, d); end
        do_access(1'b0, 32'h300, 32'h0, 4'h0, 1, 32'h0BADF00D, 1'b0, s, d);
        vecs++; if (s !== 2 || d !== 32'h0BADF00D) begin errs++; $display("FAIL inval_remiss stall=%0d data=%h exp=2/0badf00d", s, d); end
        vecs++; if (bus.oMissCount !== 32'd7) begin errs++; $display("FAIL inval_misses got=%0d exp=7", bus.oMissCount); end
        do_access(1'b0, 32'h300, 32'h0, 4'h0, 1, 32'h0, 1'b1, s, d);
        vecs++; if (s !== 0 || d !== 32'h0BADF00D) begin errs++; $display("FAIL inval_hit stall=%0d data=%h exp=0/0badf00d", s, d); end
        vecs++; if (bus.oHitCount !== 32'd4) begin errs++; $display("FAIL inval_hit_count got=%0d exp=4", bus.oHitCount); end
        do_access(1'b0, 32'h300, 32'h0, 4'h0, 1, 32'h0BADF00D, 1'b0, s, d);
        vecs++; if (s !== 2) begin errs++; $display("FAIL after_inval_hit stall=%0d exp=2", s); end
    endtask

    task automatic test_hit_wrap;
        int s; logic [31:0] d;
        @(negedge clk);
        force dut.hit_q = 32'hFFFF_FFFF;
        #1;
        release dut.hit_q;
        #1;
        vecs++; if (bus.oHitCount !== 32'hFFFF_FFFF) begin errs++; $display("FAIL preload got=%h exp=ffffffff", bus.oHitCount); end
        do_access(1'b0, 32'h300, 32'h0, 4'h0, 1, 32'h0, 1'b0, s, d);
        vecs++; if (s !== 0 || d !== 32'h0BADF00D) begin errs++; $display("FAIL wrap_hit stall=%0d data=%h exp=0/0badf00d", s, d); end
        vecs++; if (bus.oHitCount !== 32'h0) begin errs++; $display("FAIL hit_wrap got=%h exp=0", bus.oHitCount); end
        vecs++; if (bus.oMissCount !== 32'd8) begin errs++; $display("FAIL final_misses got=%0d exp=8", bus.oMissCount); end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.iReqValid  = 1'b0;
        bus.iWriteEn   = 1'b0;
        bus.iAddress   = 32'h0;
        bus.iWriteData = 32'h0;
        bus.iByteEn    = 4'h0;
        bus.iMemAck    = 1'b0;
        bus.iMemRData  = 32'h0;
        test_reset;
        test_reset_mid_refill;
        test_load_miss_hit;
        test_store_hit;
        test_store_miss;
        test_alias;
        test_invalidate;
        test_hit_wrap;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Responder on the memory-stage data port. It services the pipeline's load and store requests from a direct-mapped, write-through, no-write-allocate cache.
- It sits between the M-stage (the initiator) and a slower backing data memory reached through a req/ack handshake.
- It asserts a stall while a refill or write-through is outstanding. The hazard logic uses that stall to freeze F/D/E/M.
- It keeps hit and miss counters for performance profiling.

Parameters:
- LINES, 16, number of one-word cache lines; power of two, at least 2.
- ADDR_W, 32, byte-address width.

Ports:
- iClk  in  1  clock
- iRstN  in  1  reset
- iReqValid  in  1  M-stage has a load or store this cycle
- iWriteEn  in  1  1 = store, 0 = load
- iAddress  in  ADDR_W  byte address; bits [1:0] are ignored
- iWriteData  in  32  store data, already lane-aligned
- iByteEn  in  4  store byte enables
- iInvalidate  in  1  clear all valid bits
- oReadData  out  32  load result
- oStall  out  1  hold the pipeline
- oMemReq  out  1  backing-memory request
- oMemWe  out  1  backing write
- oMemAddr  out  ADDR_W  word-aligned address; bits [1:0] are 0
- oMemWData  out  32  backing write data
- oMemBe  out  4  backing byte enables
- iMemAck  in  1  backing memory accepted or completed the request
- iMemRData  in  32  read data, valid when iMemAck is high
- oHitCount  out  32  load-hit counter
- oMissCount  out  32  load-miss counter

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- On iRstN low, immediately:
  - state becomes IDLE;
  - all valid bits are 0;
  - oMemReq, oStall, oMemWe and oMemBe are 0;
  - oReadData, oMemAddr, oMemWData, oHitCount and oMissCount are 0.
- Reset mid-transaction abandons the request. oMemReq falls asynchronously, and the backing memory must tolerate this.
- Address split:
  - index = iAddress[2 +: log2(LINES)];
  - tag = the remaining upper bits.
  - hit = valid[index] and tag match.
- States: IDLE, REFILL, WTHRU, DONE.
- IDLE:
  - iReqValid=0: oStall=0.
  - Load hit: oReadData = line data combinationally in the same cycle; oStall=0; oHitCount increments.
  - Load miss: oStall=1 combinationally; oMissCount increments; next state REFILL; request address and type are latched.
  - Store (hit or miss): oStall=1; next state WTHRU; address, data and enables are latched.
- REFILL:
  - Outputs: oMemReq=1, oMemWe=0, oMemAddr = latched word address; oStall=1.
  - On iMemAck: write iMemRData into the line, set the tag, set valid, capture the data into a response register, go to DONE.
- WTHRU:
  - Outputs: oMemReq=1, oMemWe=1, oMemWData and oMemBe from the latch; oStall=1.
  - On iMemAck: if the latched address hits, merge the enabled bytes into the line (no allocate on miss); go to DONE.
- DONE:
  - oStall=0; oReadData = response register; oMemReq=0.
  - Next state is IDLE. The request presented in DONE is the one just completed and is not re-serviced.
- Handshake:
  - oMemReq, oMemWe, oMemAddr, oMemWData and oMemBe stay stable while req=1 and ack=0.
  - oMemReq drops on the cycle after ack.
  - Unlimited wait states are allowed; the same-cycle ack after req rise is legal.
- Latency:
  - load hit: 0 extra cycles;
  - load miss: N+1 stall cycles, where the ack arrives N cycles after req;
  - store: N+1 stall cycles.
- iInvalidate:
  - Clears all valid bits at the next edge in any state.
  - If coincident with a REFILL ack, the invalidate wins: the line stays invalid, but the data is still returned in DONE.
  - If coincident with a load hit in IDLE, the data is returned and then the line is invalid.
- Counters: 32-bit, wrap from 0xFFFFFFFF to 0. They count only IDLE load decisions; stores are not counted.
- Aliasing: two addresses with the same index and different tags replace each other on refill.

Test Plan:
- Reset with iRstN=0 mid-REFILL (oMemReq=1) -> oMemReq=0 asynchronously. After release: state IDLE, counters 0, a load to 0x100 misses.
- Load 0x100, memory acks after 3 cycles with 0xDEADBEEF -> oStall high 4 cycles, then oReadData=0xDEADBEEF in DONE, oMissCount=1. Repeat load -> 0-stall hit, oHitCount=1.
- Store to 0x100 with iWriteData=0x000000AA, iByteEn=0001, after the line is cached with 0xDEADBEEF -> oMemWe=1, oMemBe=0001 held until ack. Next load hits with 0xDEADBEAA.
- Store to uncached 0x200 -> write-through issued. Following load of 0x200 misses (no allocate).
- Alias: load 0x100, then 0x140 (same index when LINES=16), then 0x100 -> three misses.
- iInvalidate coincident with refill ack for 0x300 -> data returned, next load of 0x300 misses. Preload oHitCount to 0xFFFFFFFF, one hit -> count reads 0.
